cache_mem_responder: RTL and testbench

Memory-side responder for the data-cache line-transfer protocol. Accepts one request per transaction on the `req`/`addr_ok` handshake, then either streams a full cache line of read beats with `data_ok`, or absorbs a full write-back burst terminated by `wlast`. Backed by an internal word-addressed array, it sits opposite the dCache controller in system simulation and on-chip scratch configurations.

---
 rtl/cache_mem_pkg.sv | 10 +
 rtl/cache_mem_array.sv | 19 +
 rtl/cache_mem_responder.sv | 77 +++++++
 tb/tb_cache_mem_responder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared types, line geometry and address helper for the cache memory responder.
package cache_mem_pkg;
  localparam int DCACHE_B = 5;
  localparam int LINE_BEATS = 2 ** (DCACHE_B - 2);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  typedef enum logic [2:0] {IDLE, RLAT, RDATA, WDATA, WDONE} cmr_state_t;
  function automatic logic [31:0] word_index(input logic [31:0] a);
    return a >> 2;
  endfunction
endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array: single-port synchronous RAM with registered read data that holds between reads.
module cache_mem_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder streaming line refills and absorbing write-back bursts.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int BEATS      = LINE_BEATS,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wlast,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);
  localparam int BW = $clog2(BEATS);
  localparam int LW = $clog2(LATENCY + 1);
  localparam int NW = DEPTH_LOG2 - BW;
  cmr_state_t state, state_n;
  logic [NW-1:0] line;
  logic [BW-1:0] beat, sel;
  logic [LW-1:0] cnt;
  logic [31:0] wi;
  logic last, we, re, unused;
  assign wi = word_index(addr);
  assign unused = &{1'b0, wi[31:DEPTH_LOG2], wi[BW-1:0]};
  assign last = beat == BW'(BEATS - 1);
  assign addr_ok = state == IDLE && req;
  assign busy = state != IDLE;
  assign we = state == WDATA && req;
  // the read is issued one cycle ahead so each beat's data lands with its data_ok
  assign re = (state == RLAT && cnt == '0) || (state == RDATA && !last);
  assign sel = state == RDATA ? beat + BW'(1) : state == WDATA ? beat : '0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (req ? (wr ? WDATA : RLAT) : IDLE)
            : state == RLAT  ? (cnt == '0 ? RDATA : RLAT)
            : state == RDATA ? (last ? IDLE : RDATA)
            : state == WDATA ? (we && last ? WDONE : WDATA)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      line    <= '0;
      beat    <= '0;
      cnt     <= '0;
      data_ok <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      data_ok <= re || we;
      if (addr_ok) begin
        line <= wi[DEPTH_LOG2-1:BW];
        beat <= '0;
        cnt  <= LW'(LATENCY - 1);
      end else if (state == RDATA || we) beat <= beat + BW'(1);
      else if (state == RLAT && cnt != '0) cnt <= cnt - LW'(1);
      if (we && wlast != last) err <= 1'b1;
    end
  end
  cache_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .re   (re),
    .addr ({line, sel}),
    .wdata(wdata),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: randomized bench against a word-array model of the responder.
module tb_cache_mem_responder;
  localparam int BEATS = 8, DEPTH_LOG2 = 12, LATENCY = 2, DEPTH = 1 << DEPTH_LOG2;
  logic clk = 0, reset = 1, req = 0, wr = 0, wlast = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic addr_ok, data_ok, busy, err;
  logic [31:0] rdata;
  int total = 0, bad = 0;
  logic [31:0] model [DEPTH];
  logic err_exp = 0;
  logic [31:0] lines [$];

  cache_mem_responder #(.BEATS(BEATS), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata), .wlast(wlast),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req = r; wr = w; wlast = l; addr = a; wdata = d;
    #1;
  endtask

  function automatic int base_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH) / BEATS * BEATS;
  endfunction

  task automatic write_burst(input logic [31:0] a, input logic [31:0] d [BEATS], input int stall_mask, input int bad_beat);
    int b, oks;
    logic prev;
    b = base_of(a);
    oks = 0;
    prev = 0;
    cyc(1, 1, 0, a, 0);
    check("wr_addr_ok", addr_ok, 1);
    for (int k = 0; k < BEATS; k++) begin
      cyc(1, 1'($urandom_range(0, 1)), k == BEATS - 1 || k == bad_beat, $urandom, d[k]);
      check("wr_data_ok", data_ok, prev);
      check("wr_busy", busy, 1);
      check("wr_addr_ok_busy", addr_ok, 0);
      oks += int'(data_ok);
      prev = 1;
      model[b + k] = d[k];
      if (k == bad_beat && k != BEATS - 1) err_exp = 1;
      if (stall_mask[k] && k < BEATS - 1)
        for (int s = 0; s < 2; s++) begin
          cyc(0, 0, 0, $urandom, $urandom);
          check("wr_stall_data_ok", data_ok, prev);
          oks += int'(data_ok);
          prev = 0;
        end
    end
    cyc(0, 0, 0, 0, 0);
    check("wr_done_data_ok", data_ok, 1);
    check("wr_done_busy", busy, 1);
    oks += int'(data_ok);
    cyc(0, 0, 0, 0, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_idle_data_ok", data_ok, 0);
    check("wr_err", err, err_exp);
    check("wr_beat_count", oks, BEATS);
    lines.push_back(a);
  endtask

  task automatic read_line(input logic [31:0] a, input logic poke, input int abort_beat);
    int b;
    b = base_of(a);
    cyc(1, 0, 0, a, 0);
    check("rd_addr_ok", addr_ok, 1);
    for (int c = 1; c <= LATENCY + BEATS; c++) begin
      int k;
      k = c - LATENCY - 1;
      cyc(poke ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 0, $urandom, 0);
      reset = k == abort_beat;
      check("rd_busy", busy, 1);
      check("rd_addr_ok_busy", addr_ok, 0);
      check("rd_data_ok", data_ok, k >= 0);
      if (k >= 0) check("rd_rdata", rdata, model[b + k]);
      if (k == abort_beat) begin
        cyc(0, 0, 0, 0, 0);
        reset = 0;
        err_exp = 0;
        check("rst_data_ok", data_ok, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        return;
      end
    end
    cyc(0, 0, 0, 0, 0);
    check("rd_idle_busy", busy, 0);
    check("rd_idle_data_ok", data_ok, 0);
    check("rd_hold_rdata", rdata, model[b + BEATS - 1]);
    check("rd_err", err, err_exp);
  endtask

  initial begin
    logic [31:0] d [BEATS];
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr_ok", addr_ok, 0);
    check("reset_data_ok", data_ok, 0);
    check("reset_rdata", rdata, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    reset = 0;
    for (int k = 0; k < BEATS; k++) d[k] = 32'hA0 + k;
    write_burst(32'h400, d, 0, -1);
    read_line(32'h404, 0, -1);
    for (int k = 0; k < BEATS; k++) d[k] = 32'hB0 + k;
    write_burst(32'h800, d, 0, -1);
    read_line(32'h800, 0, -1);
    for (int k = 0; k < BEATS; k++) d[k] = 32'hC0 + k;
    write_burst(32'hC00, d, (1 << 2) | (1 << 5), -1);
    read_line(32'hC1C, 0, -1);
    for (int k = 0; k < BEATS; k++) d[k] = $urandom;
    write_burst(32'h1000, d, 0, 3);
    read_line(32'h1000, 0, -1);
    read_line(32'h400, 1, -1);
    read_line(32'h800, 0, 4);
    read_line(32'h800, 0, -1);
    for (int k = 0; k < BEATS; k++) d[k] = $urandom;
    write_burst(32'h4000_0C00, d, 0, -1);
    read_line(32'hC00, 0, -1);
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < BEATS; k++) d[k] = $urandom;
      write_burst($urandom, d, int'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1);
      read_line(lines[$urandom_range(0, lines.size() - 1)] ^ 32'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
